// File: rtl/hmac_sha1_pkg.sv
// rtl/hmac_sha1_pkg.sv - shared widths and output-FSM state encodings for the HMAC-SHA1 datapath
package hmac_sha1_pkg;

    localparam int DATA_W    = 32;
    localparam int DIGEST_W  = 160;
    localparam int NUM_WORDS = DIGEST_W / DATA_W;

    // 2'b10 is deliberately unused; the FSM steers it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b11
    } out_state_e;

endpackage

// File: rtl/digest_out_ctrl.sv
// rtl/digest_out_ctrl.sv - serialises a 160-bit SHA-1 digest onto an AXIS master port (DIGEST_BYTE_SWAP_EN: byte-reversed beats)
module digest_out_ctrl #(
    parameter int DATA_W   = hmac_sha1_pkg::DATA_W,
    parameter int DIGEST_W = hmac_sha1_pkg::DIGEST_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                digest_valid,
    output logic                digest_ready,
    output logic [DATA_W-1:0]   m_t_data,
    output logic                m_t_valid,
    output logic                m_t_last,
    input  logic                m_t_ready,
    output logic                busy,
    output logic                out_done
);

    localparam int NUM_WORDS = DIGEST_W / DATA_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    hmac_sha1_pkg::out_state_e state_q, state_d;
    logic [DIGEST_W-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      is_last;
    logic [DATA_W-1:0]         beat_w;
    logic [DATA_W-1:0]         beat_out;

    assign is_last = (cnt_q == CNT_W'(NUM_WORDS - 1));
    assign beat_w  = shift_q[DIGEST_W-1 -: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= hmac_sha1_pkg::ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            hmac_sha1_pkg::ST_IDLE: begin
                if (digest_valid) begin
                    shift_d = digest;
                    cnt_d   = '0;
                    state_d = hmac_sha1_pkg::ST_SEND;
                end
            end
            hmac_sha1_pkg::ST_SEND: begin
                // m_t_valid is constant high here, so ready alone marks a beat.
                if (m_t_ready) begin
                    shift_d = shift_q << DATA_W;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        state_d = hmac_sha1_pkg::ST_DONE;
                    end
                end
            end
            hmac_sha1_pkg::ST_DONE: state_d = hmac_sha1_pkg::ST_IDLE;
            default:                state_d = hmac_sha1_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        beat_out = beat_w;
`ifdef DIGEST_BYTE_SWAP_EN
        for (int b = 0; b < DATA_W / 8; b++) begin
            beat_out[8*b +: 8] = beat_w[DATA_W-8-8*b +: 8];
        end
`endif
    end

    // Every output is a decode of registered state; m_t_ready never reaches an output.
    assign m_t_data     = beat_out;
    assign m_t_valid    = (state_q == hmac_sha1_pkg::ST_SEND);
    assign m_t_last     = m_t_valid && is_last;
    assign digest_ready = (state_q == hmac_sha1_pkg::ST_IDLE);
    assign busy         = (state_q != hmac_sha1_pkg::ST_IDLE);
    assign out_done     = (state_q == hmac_sha1_pkg::ST_DONE);

endmodule
